mux_clock_display: RTL and testbench

//  24-hour HH:MM:SS timekeeper with a 4-digit multiplexed 7-segment driver.

---
 rtl/mux_clock_display.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mux_clock_display.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_clock_display.sv
// HH:MM:SS timekeeper with push-button setting and a
// 4-digit multiplexed 7-segment driver, clock-enable timed.
module mux_clock_display_deb #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [DW-1:0] cnt;
  logic          accept;

  assign accept = (sync[1] != level) && (cnt == CNT_LAST);
  assign press  = accept && sync[1];

  // synchronise the raw pin, then accept a level after a stable run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b00;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module mux_clock_display #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter bit SHOW_HOURS = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [6:0]  catodes,
  output logic [3:0]  digits,
  output logic        secondsPoint,
  output logic [23:0] time_bcd,
  output logic        sec_tick
);

  localparam int HALF = CLK_HZ / 2;
  localparam int SCAN = CLK_HZ / SCAN_HZ;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SW   = (SCAN > 1) ? $clog2(SCAN) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN - 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_SET_HI = 2'd1;
  localparam logic [1:0] ST_SET_LO = 2'd2;

  logic [HW-1:0] half_cnt;
  logic [SW-1:0] scan_cnt;
  logic          half_tick;
  logic          scan_tick;

  logic [1:0] state;
  logic       blink;
  logic       mode_p;
  logic       inc_p;
  logic       inc_apply;
  logic       run_adv;
  logic       run_entry;

  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic [7:0] hh_n;
  logic [7:0] mm_n;
  logic [7:0] ss_n;
  logic [7:0] hi_inc;
  logic [7:0] lo_inc;

  logic [1:0]  digit_idx;
  logic [1:0]  next_idx;
  logic [15:0] disp;
  logic [3:0]  nib;
  logic        blank;

  function automatic logic [7:0] inc_60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_24(input logic [7:0] v);
    if (v == 8'h23) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h08;
      4'd1:    return 7'h6E;
      4'd2:    return 7'h12;
      4'd3:    return 7'h42;
      4'd4:    return 7'h64;
      4'd5:    return 7'h41;
      4'd6:    return 7'h01;
      4'd7:    return 7'h6A;
      4'd8:    return 7'h00;
      4'd9:    return 7'h40;
      default: return 7'h7F;
    endcase
  endfunction

  mux_clock_display_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .btn   (btn_mode),
    .press (mode_p)
  );

  mux_clock_display_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .btn   (btn_inc),
    .press (inc_p)
  );

  assign half_tick = (half_cnt == HALF_LAST);
  assign scan_tick = (scan_cnt == SCAN_LAST);
  assign run_adv   = (state == ST_RUN) && half_tick && secondsPoint;
  assign run_entry = (state == ST_SET_LO) && mode_p;
  assign inc_apply = inc_p && !mode_p && (state != ST_RUN);

  assign time_bcd = {hh, mm, ss};

  // one-second cascade; a carry ripples only out of a 59
  always_comb begin
    ss_n = inc_60(ss);
    mm_n = mm;
    hh_n = hh;
    if (ss == 8'h59) begin
      mm_n = inc_60(mm);
      if (mm == 8'h59) hh_n = inc_24(hh);
    end
  end

  // edited-field increments, no carry between fields
  always_comb begin
    hi_inc = SHOW_HOURS ? inc_24(hh) : inc_60(mm);
    lo_inc = SHOW_HOURS ? inc_60(mm) : inc_60(ss);
  end

  // half-second and scan prescalers; RUN entry restarts the second
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      half_cnt <= '0;
      scan_cnt <= '0;
    end else begin
      if (half_tick || run_entry) half_cnt <= '0;
      else half_cnt <= half_cnt + 1'b1;
      if (scan_tick) scan_cnt <= '0;
      else scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // mode FSM, colon, second pulse and blink phase
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state        <= ST_RUN;
      secondsPoint <= 1'b0;
      sec_tick     <= 1'b0;
      blink        <= 1'b0;
    end else begin
      sec_tick <= run_adv;
      if (inc_apply) blink <= 1'b0;
      else if (half_tick) blink <= ~blink;
      case (state)
        ST_RUN: begin
          if (half_tick) secondsPoint <= ~secondsPoint;
          if (mode_p) state <= ST_SET_HI;
        end
        ST_SET_HI: begin
          secondsPoint <= 1'b1;
          if (mode_p) state <= ST_SET_LO;
        end
        ST_SET_LO: begin
          secondsPoint <= 1'b1;
          if (mode_p) begin
            state        <= ST_RUN;
            secondsPoint <= 1'b0;
          end
        end
        default: begin
          state        <= ST_RUN;
          secondsPoint <= 1'b0;
        end
      endcase
    end
  end

  // BCD time: running advance, field edits, seconds clear on RUN entry
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      hh <= 8'h00;
      mm <= 8'h00;
      ss <= 8'h00;
    end else if (run_adv) begin
      hh <= hh_n;
      mm <= mm_n;
      ss <= ss_n;
    end else if (inc_apply && state == ST_SET_HI) begin
      if (SHOW_HOURS) hh <= hi_inc;
      else mm <= hi_inc;
    end else if (inc_apply && state == ST_SET_LO) begin
      if (SHOW_HOURS) mm <= lo_inc;
      else ss <= lo_inc;
    end else if (run_entry && SHOW_HOURS) begin
      ss <= 8'h00;
    end
  end

  assign next_idx = digit_idx + 2'd1;
  assign disp     = SHOW_HOURS ? {hh, mm} : {mm, ss};
  assign nib      = disp[{next_idx, 2'b00} +: 4];

  // the edited field blanks while blink is high
  always_comb begin
    blank = 1'b0;
    unique case (1'b1)
      state == ST_SET_HI: blank = blink && next_idx[1];
      state == ST_SET_LO: blank = blink && !next_idx[1];
      default:            blank = 1'b0;
    endcase
  end

  // digit rotation with the glyph registered alongside it
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      digit_idx <= 2'd0;
      digits    <= 4'b1110;
      catodes   <= 7'h7F;
    end else if (scan_tick) begin
      digit_idx <= next_idx;
      digits    <= {digits[2:0], digits[3]};
      catodes   <= blank ? 7'h7F : glyph(nib);
    end
  end

endmodule

// File: tb/tb_mux_clock_display.sv
// Scoreboard bench for mux_clock_display with a
// seconds-count reference model and randomized button timing.
module tb_mux_clock_display;

  localparam int CLK_HZ = 20;
  localparam int SCAN_HZ = 5;
  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bm = 1'b0;
  logic        bi = 1'b0;
  logic [6:0]  catodes;
  logic [3:0]  digits;
  logic        sp;
  logic [23:0] time_bcd;
  logic        sec_tick;

  typedef struct {
    int          cyc;
    logic [23:0] t;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc;
  logic [6:0] glyph_tab [10];

  always #5 clk = ~clk;

  mux_clock_display #(
    .CLK_HZ     (CLK_HZ),
    .SCAN_HZ    (SCAN_HZ),
    .DEB_CYCLES (DEB),
    .SHOW_HOURS (1'b1)
  ) dut (
    .CLOCK_50     (clk),
    .RESET        (rst),
    .btn_mode     (bm),
    .btn_inc      (bi),
    .catodes      (catodes),
    .digits       (digits),
    .secondsPoint (sp),
    .time_bcd     (time_bcd),
    .sec_tick     (sec_tick)
  );

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [23:0] to_bcd(int secs);
    int h, m, s;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10),
            4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int digit_val(int secs, int pos);
    int h, m;
    h = secs / 3600;
    m = (secs / 60) % 60;
    case (pos)
      0: return m % 10;
      1: return m / 10;
      2: return h % 10;
      default: return h / 10;
    endcase
  endfunction

  // scoreboard monitor: every second pulse consumes one expectation
  always @(negedge clk) begin
    if (!rst && sec_tick) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_tick: time %h at cycle %0d", time_bcd, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("tick_time", 32'(time_bcd), 32'(mon_e.t));
        if (mon_e.cyc >= 0) chk("tick_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic cyc_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bm = 1'b0;
    bi = 1'b0;
    cyc_n(2);
    rst = 1'b0;
  endtask

  task automatic press(bit m, bit i, int hold);
    bm = m;
    bi = i;
    cyc_n(hold);
    bm = 1'b0;
    bi = 1'b0;
    cyc_n(7 + int'($urandom_range(0, 3)));
  endtask

  task automatic wait_sb(int budget, string name);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d ticks outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_low(int secs, string name);
    logic [3:0] pat;
    int k;
    for (int p = 0; p < 2; p++) begin
      pat = ~(4'b0001 << p);
      k = 0;
      while (digits !== pat && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk({name, "_digits"}, 32'(digits), 32'(pat));
      chk({name, "_glyph"}, 32'(catodes),
          32'(glyph_tab[digit_val(secs, p)]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m_secs;
    int n_blank, n_real, n_bad;
    logic [3:0] pat;
    glyph_tab = '{7'h08, 7'h6E, 7'h12, 7'h42, 7'h64,
                  7'h41, 7'h01, 7'h6A, 7'h00, 7'h40};

    // reset state, prescaler timing and scan order
    do_reset();
    chk("rst_digits", 32'(digits), 32'h0000000E);
    chk("rst_catodes", 32'(catodes), 32'h7F);
    chk("rst_sp", 32'(sp), 0);
    chk("rst_time", 32'(time_bcd), 0);
    chk("rst_tick", 32'(sec_tick), 0);
    sb.push_back('{20, to_bcd(1)});
    sb.push_back('{40, to_bcd(2)});
    for (int c = 1; c <= 41; c++) begin
      @(negedge clk);
      if (c == 3) begin
        chk("scan_c3_digits", 32'(digits), 32'hE);
        chk("scan_c3_catodes", 32'(catodes), 32'h7F);
      end
      if (c % 4 == 0 && c <= 16) begin
        pat = ~(4'b0001 << ((c / 4) % 4));
        chk("scan_digits", 32'(digits), 32'(pat));
        chk("scan_catodes", 32'(catodes), 32'h08);
      end
      if (c == 9 || c == 20) chk("colon_lo", 32'(sp), 0);
      if (c == 10 || c == 19) chk("colon_hi", 32'(sp), 1);
    end
    chk("run_40", 32'(time_bcd), 32'(to_bcd(2)));
    wait_sb(5, "run_40_ticks");

    // set 23:59 then run through midnight
    do_reset();
    press(1, 0, 6);
    m_secs = 0;
    for (int k = 0; k < 23; k++) begin
      press(0, 1, 4 + int'($urandom_range(0, 3)));
      m_secs = (m_secs + 3600) % 86400;
    end
    chk("set_hours", 32'(time_bcd), 32'(to_bcd(m_secs)));
    chk("set_colon", 32'(sp), 1);
    check_low(m_secs, "set_hi_low");
    press(1, 0, 6);
    for (int k = 0; k < 59; k++) begin
      press(0, 1, 4 + int'($urandom_range(0, 3)));
      m_secs = (m_secs / 3600) * 3600 + (((m_secs / 60) % 60 + 1) % 60) * 60;
    end
    chk("set_minutes", 32'(time_bcd), 32'(to_bcd(m_secs)));
    press(1, 0, 6);
    chk("run_entry", 32'(time_bcd), 32'(to_bcd(m_secs)));
    for (int k = 1; k <= 60; k++)
      sb.push_back('{-1, to_bcd((m_secs + k) % 86400)});
    wait_sb(1400, "midnight_ticks");
    chk("midnight", 32'(time_bcd), 0);

    // field wrap and blink in SET_HI
    do_reset();
    press(1, 0, 6);
    m_secs = 0;
    for (int k = 0; k < 25; k++) begin
      press(0, 1, 4 + int'($urandom_range(0, 3)));
      m_secs = (m_secs + 3600) % 86400;
    end
    chk("hour_wrap", 32'(time_bcd), 32'(to_bcd(m_secs)));
    n_blank = 0;
    n_real = 0;
    n_bad = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        pat = ~(4'b0001 << p);
        if (digits === pat) begin
          if (p >= 2 && catodes === 7'h7F) n_blank++;
          else if (catodes === glyph_tab[digit_val(m_secs, p)]) n_real++;
          else n_bad++;
        end
      end
    end
    n_chk++;
    if (n_blank == 0 || n_real == 0 || n_bad != 0) begin
      n_fail++;
      $display("FAIL blink: blank %0d real %0d bad %0d, need >0 >0 0",
               n_blank, n_real, n_bad);
    end

    // glitch rejection, single increment, simultaneous presses
    press(0, 1, 2);
    chk("glitch", 32'(time_bcd), 32'(to_bcd(m_secs)));
    press(0, 1, 6);
    m_secs = m_secs + 3600;
    chk("one_inc", 32'(time_bcd), 32'(to_bcd(m_secs)));
    press(1, 1, 6);
    chk("mode_wins", 32'(time_bcd), 32'(to_bcd(m_secs)));
    press(0, 1, 6);
    m_secs = m_secs + 60;
    chk("now_set_lo", 32'(time_bcd), 32'(to_bcd(m_secs)));

    // asynchronous reset mid-set
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_digits", 32'(digits), 32'hE);
    chk("async_catodes", 32'(catodes), 32'h7F);
    chk("async_sp", 32'(sp), 0);
    chk("async_time", 32'(time_bcd), 0);
    chk("async_tick", 32'(sec_tick), 0);
    cyc_n(2);
    rst = 1'b0;
    sb.push_back('{20, to_bcd(1)});
    cyc_n(10);
    chk("post_rst_colon", 32'(sp), 1);
    wait_sb(30, "post_rst_run");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
